// File: rtl/verilog_divider.sv
// IEEE754 single-precision divider: res = op1 / op2, restoring, RNE, subnormals flushed to zero.
// Latency: 3 edges (capture to done) for special operands, 33 edges for every numeric path.
// Handshake: ready sampled only in ST_START; done pulses one cycle; res held until the next result.
module verilog_divider #(
  parameter int QBITS = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] res,
  output logic        done
);

  typedef enum logic [3:0] {
    ST_START, ST_EVAL, ST_CHECK, ST_ELAB, ST_DIV,
    ST_NORM, ST_ROUND, ST_RANGE, ST_FINISH
  } state_t;

  localparam logic [1:0] C_ZER = 2'd0;
  localparam logic [1:0] C_NUM = 2'd1;
  localparam logic [1:0] C_INF = 2'd2;
  localparam logic [1:0] C_NAN = 2'd3;

  state_t             r_state, w_state_nxt;
  logic               r_sign1, r_sign2;
  logic [7:0]         r_exp1, r_exp2;
  logic [23:0]        r_mant1, r_mant2;
  logic [1:0]         r_cls1, r_cls2, r_cls;
  logic signed [9:0]  r_e;
  logic [24:0]        r_rem;
  logic [23:0]        r_div;
  logic [QBITS-1:0]   r_q;
  logic [4:0]         r_cnt;
  logic [23:0]        r_sig;
  logic               r_guard, r_sticky;
  logic [30:0]        r_num;

  logic               w_rem_ge;
  logic [24:0]        w_rem_nxt;
  logic [24:0]        w_sig_inc;
  logic [1:0]         w_cls_chk;
  logic [30:0]        w_res_fin;
  logic               w_done_nxt;

  // Classify one operand from its captured exponent and significand.
  function automatic logic [1:0] classify(input logic [7:0] exp, input logic [23:0] mant);
    if (exp == 8'hFF) classify = (mant[22:0] == 23'd0) ? C_INF : C_NAN;
    else if (exp == 8'h00) classify = C_ZER;
    else classify = C_NUM;
  endfunction

  // Restoring step, result-class resolution and rounding increment.
  always_comb begin
    w_rem_ge  = (r_rem >= {1'b0, r_div});
    w_rem_nxt = w_rem_ge ? (r_rem - {1'b0, r_div}) : r_rem;
    w_sig_inc = {1'b0, r_sig} + 25'd1;
    if (r_cls1 == C_NAN || r_cls2 == C_NAN ||
        (r_cls1 == C_ZER && r_cls2 == C_ZER) ||
        (r_cls1 == C_INF && r_cls2 == C_INF))
      w_cls_chk = C_NAN;
    else if (r_cls1 == C_INF || r_cls2 == C_ZER)
      w_cls_chk = C_INF;
    else if (r_cls1 == C_ZER || r_cls2 == C_INF)
      w_cls_chk = C_ZER;
    else
      w_cls_chk = C_NUM;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_START;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_START:  if (ready) w_state_nxt = ST_EVAL;
      ST_EVAL:   w_state_nxt = ST_CHECK;
      ST_CHECK:  w_state_nxt = (w_cls_chk == C_NUM) ? ST_ELAB : ST_FINISH;
      ST_ELAB:   w_state_nxt = ST_DIV;
      ST_DIV:    if (r_cnt == 5'(QBITS - 1)) w_state_nxt = ST_NORM;
      ST_NORM:   w_state_nxt = ST_ROUND;
      ST_ROUND:  w_state_nxt = ST_RANGE;
      ST_RANGE:  w_state_nxt = ST_FINISH;
      ST_FINISH: w_state_nxt = ST_START;
      default:   w_state_nxt = ST_START;
    endcase
  end

  // Output values presented when leaving ST_FINISH.
  always_comb begin
    w_done_nxt = (r_state == ST_FINISH);
    case (r_cls)
      C_ZER:   w_res_fin = 31'h0;
      C_INF:   w_res_fin = 31'h7F800000;
      C_NAN:   w_res_fin = 31'h7FFFFFFF;
      default: w_res_fin = r_num;
    endcase
  end

  // Datapath: operand capture, division loop, normalise, round, range check, result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sign1 <= 1'b0; r_sign2 <= 1'b0;
      r_exp1  <= 8'd0; r_exp2  <= 8'd0;
      r_mant1 <= 24'd0; r_mant2 <= 24'd0;
      r_cls1  <= C_ZER; r_cls2 <= C_ZER; r_cls <= C_ZER;
      r_e     <= 10'sd0;
      r_rem   <= 25'd0; r_div <= 24'd0; r_q <= '0; r_cnt <= 5'd0;
      r_sig   <= 24'd0; r_guard <= 1'b0; r_sticky <= 1'b0;
      r_num   <= 31'd0;
      res     <= 32'd0;
      done    <= 1'b0;
    end else begin
      done <= w_done_nxt;
      case (r_state)
        ST_START: begin
          r_sign1 <= op1[31]; r_exp1 <= op1[30:23]; r_mant1 <= {1'b1, op1[22:0]};
          r_sign2 <= op2[31]; r_exp2 <= op2[30:23]; r_mant2 <= {1'b1, op2[22:0]};
        end
        ST_EVAL: begin
          r_cls1 <= classify(r_exp1, r_mant1);
          r_cls2 <= classify(r_exp2, r_mant2);
        end
        ST_CHECK: r_cls <= w_cls_chk;
        ST_ELAB: begin
          r_e   <= $signed({2'b00, r_exp1}) - $signed({2'b00, r_exp2}) + 10'sd127;
          r_rem <= {1'b0, r_mant1};
          r_div <= r_mant2;
          r_q   <= '0;
          r_cnt <= 5'd0;
        end
        ST_DIV: begin
          r_rem <= w_rem_nxt << 1;
          r_q   <= {r_q[QBITS-2:0], w_rem_ge};
          r_cnt <= r_cnt + 5'd1;
        end
        ST_NORM: begin
          if (r_q[QBITS-1]) begin
            r_sig    <= r_q[QBITS-1 -: 24];
            r_guard  <= r_q[QBITS-25];
            r_sticky <= (r_rem != 25'd0) | r_q[0];
          end else begin
            r_sig    <= r_q[QBITS-2 -: 24];
            r_guard  <= r_q[QBITS-26];
            r_sticky <= (r_rem != 25'd0);
            r_e      <= r_e - 10'sd1;
          end
        end
        ST_ROUND: begin
          if (r_guard & (r_sticky | r_sig[0])) begin
            if (w_sig_inc[24]) begin
              r_sig <= 24'h800000;
              r_e   <= r_e + 10'sd1;
            end else begin
              r_sig <= w_sig_inc[23:0];
            end
          end
        end
        ST_RANGE: begin
          if (r_e <= 10'sd0)        r_cls <= C_ZER;
          else if (r_e >= 10'sd255) r_cls <= C_INF;
          else                      r_num <= {r_e[7:0], r_sig[22:0]};
        end
        ST_FINISH: res <= {r_sign1 ^ r_sign2, w_res_fin};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_verilog_divider.sv
// Scoreboard bench for verilog_divider: directed operand pairs with hand-computed quotients.
// Expected result and capture edge are queued at issue; a monitor checks value and latency on done.
// Also covers idle-after-reset and a reset that aborts an operation mid-division.
module tb_verilog_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] op1 = 32'd0;
  logic [31:0] op2 = 32'd0;
  logic [31:0] res;
  logic        done;

  verilog_divider #(.QBITS(26)) dut (
    .clk(clk), .rst(rst), .ready(ready), .op1(op1), .op2(op2), .res(res), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          cap;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  // Monitor: every done pulse is matched against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 at edge %0d, required no pending operation", cyc);
      end else begin
        exp_t  e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (res !== e.res) begin
          errors++;
          $display("FAIL %s_res: got %08h, required %08h", nm, res, e.res);
        end
        checks++;
        if (cyc - e.cap != e.lat) begin
          errors++;
          $display("FAIL %s_latency: got %0d edges, required %0d", nm, cyc - e.cap, e.lat);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input int lat, input string nm,
                       input bit expect_it);
    exp_t e;
    @(negedge clk);
    op1   = a;
    op2   = b;
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    if (expect_it) begin
      e.res = r;
      e.lat = lat;
      e.cap = cyc;
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d results pending, required 0", nm, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse: done=%b one cycle later, required 0", nm, done);
    end
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input int lat, input string nm);
    issue(a, b, r, lat, nm, 1'b1);
    wait_idle(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Idle after reset: outputs stay cleared.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i % 5 == 4) begin
        checks++;
        if (res !== 32'h0) begin
          errors++;
          $display("FAIL idle_res: got %08h, required 00000000", res);
        end
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL idle_done: got %b, required 0", done);
        end
      end
    end

    // Numeric paths.
    run(32'h40C00000, 32'h40000000, 32'h40400000, 33, "six_div_two");
    run(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 33, "one_third");
    run(32'hC0000000, 32'h3F000000, 32'hC0800000, 33, "neg_two_div_half");

    // Reset while in ST_DIV: capture edge E0, rst low sampled at E0+10.
    issue(32'h40C00000, 32'h40000000, 32'h0, 0, "aborted", 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (res !== 32'h0) begin
      errors++;
      $display("FAIL abort_res: got %08h, required 00000000", res);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL abort_done: got %b, required 0", done);
    end
    rst = 1'b1;
    repeat (40) @(negedge clk);
    run(32'h40C00000, 32'h40000000, 32'h40400000, 33, "after_abort");

    // Special operand classes.
    run(32'hBF800000, 32'h00000000, 32'hFF800000, 3, "neg_div_zero");
    run(32'h00000000, 32'h00000000, 32'h7FFFFFFF, 3, "zero_div_zero");
    run(32'hFF800000, 32'h7F800000, 32'hFFFFFFFF, 3, "inf_div_inf");
    run(32'h3F800000, 32'h7F800000, 32'h00000000, 3, "one_div_inf");

    // Exponent range limits.
    run(32'h7F000000, 32'h3E800000, 32'h7F800000, 33, "overflow");
    run(32'h00800000, 32'h40000000, 32'h00000000, 33, "underflow");

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
